// File: rtl/intellight_pkg.sv
// Shared state encoding and default parameters for the intellight phase sequencer.
package intellight_pkg;

  localparam int N_PHASE_DEF       = 4;
  localparam int CNT_W_DEF         = 16;
  localparam int GREEN_CYCLES_DEF  = 30;
  localparam int YELLOW_CYCLES_DEF = 4;
  localparam int ALLRED_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GREEN  = 3'd1,
    DECIDE = 3'd2,
    YELLOW = 3'd3,
    ALLRED = 3'd4
  } seq_state_t;

endpackage

// File: rtl/intellight_phase_sequencer_if.sv
// Agent-to-sequencer action handshake: the agent (master) offers a phase, the sequencer (slave) accepts it.
interface intellight_phase_sequencer_if #(
  parameter int PH_W = 2
);

  logic            act_valid;
  logic [PH_W-1:0] act_phase;
  logic            act_ready;

  modport master (output act_valid, output act_phase, input act_ready);
  modport slave  (input act_valid, input act_phase, output act_ready);

endinterface

// File: rtl/intellight_interval_cnt.sv
// Loadable interval down-counter: a load of 0 is clamped to 1, and expire is high on the last cycle.
module intellight_interval_cnt
  import intellight_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val == '0) ? CNT_W'(1) : load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/intellight_phase_sequencer.sv
// GREEN -> YELLOW -> ALL-RED signal sequencer driven by agent decisions.
// Define INTELLIGHT_SWITCH_CNT_EN to build the live 32-bit phase-change counter; otherwise switch_cnt is 0.
module intellight_phase_sequencer
  import intellight_pkg::*;
#(
  parameter int N_PHASE = N_PHASE_DEF,
  parameter int PH_W    = $clog2(N_PHASE),
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          enable,
  input  logic [CNT_W-1:0]              green_cycles,
  input  logic [CNT_W-1:0]              yellow_cycles,
  input  logic [CNT_W-1:0]              allred_cycles,
  intellight_phase_sequencer_if.slave   act_if,
  output logic [N_PHASE-1:0]            light_green,
  output logic [N_PHASE-1:0]            light_yellow,
  output logic [PH_W-1:0]               cur_phase,
  output logic [2:0]                    seq_state,
  output logic                          step_done,
  output logic                          act_err,
  output logic [31:0]                   switch_cnt
);

  localparam logic [PH_W:0] N_PHASE_EXT = (PH_W + 1)'(N_PHASE);

  seq_state_t        state_q, state_d;
  logic [PH_W-1:0]   cur_phase_q, cur_phase_d;
  logic [PH_W-1:0]   pend_phase_q, pend_phase_d;
  logic              pend_valid_q, pend_valid_d;
  logic              act_ready_q, act_ready_d;
  logic              step_done_q, step_done_d;
  logic              act_err_q, act_err_d;
  logic [N_PHASE-1:0] light_green_q, light_green_d;
  logic [N_PHASE-1:0] light_yellow_q, light_yellow_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_dec;
  logic              cnt_expire;
  logic              accept;
  logic              phase_oor;

  assign accept    = act_if.act_valid && act_ready_q;
  assign phase_oor = ({1'b0, act_if.act_phase} >= N_PHASE_EXT);
  assign cnt_dec   = (state_q == GREEN) || (state_q == YELLOW) || (state_q == ALLRED);

  intellight_interval_cnt #(
    .CNT_W (CNT_W)
  ) u_interval_cnt (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .expire   (cnt_expire)
  );

  always_comb begin
    state_d        = state_q;
    cur_phase_d    = cur_phase_q;
    pend_phase_d   = pend_phase_q;
    pend_valid_d   = pend_valid_q;
    act_err_d      = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_val   = green_cycles;
    act_ready_d    = 1'b0;
    step_done_d    = 1'b0;
    light_green_d  = '0;
    light_yellow_d = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (phase_oor) begin
            act_err_d = 1'b1;
          end else begin
            cur_phase_d  = act_if.act_phase;
            state_d      = GREEN;
            cnt_load     = 1'b1;
            cnt_load_val = green_cycles;
          end
        end
      end
      GREEN: begin
        if (cnt_expire) begin
          state_d = DECIDE;
        end
      end
      // A repeat of the served phase or an invalid phase extends green without a yellow.
      DECIDE: begin
        if (accept) begin
          if (phase_oor || (act_if.act_phase == cur_phase_q)) begin
            act_err_d    = phase_oor;
            state_d      = GREEN;
            cnt_load     = 1'b1;
            cnt_load_val = green_cycles;
          end else begin
            pend_phase_d = act_if.act_phase;
            pend_valid_d = 1'b1;
            state_d      = YELLOW;
            cnt_load     = 1'b1;
            cnt_load_val = yellow_cycles;
          end
        end else if (!enable) begin
          pend_valid_d = 1'b0;
          state_d      = YELLOW;
          cnt_load     = 1'b1;
          cnt_load_val = yellow_cycles;
        end
      end
      YELLOW: begin
        if (cnt_expire) begin
          state_d      = ALLRED;
          cnt_load     = 1'b1;
          cnt_load_val = allred_cycles;
        end
      end
      ALLRED: begin
        if (cnt_expire) begin
          if (pend_valid_q) begin
            cur_phase_d  = pend_phase_q;
            pend_valid_d = 1'b0;
            state_d      = GREEN;
            cnt_load     = 1'b1;
            cnt_load_val = green_cycles;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so every output leaves a flop.
    act_ready_d = (state_d == DECIDE) || ((state_d == IDLE) && enable);
    step_done_d = (state_d == DECIDE) && (state_q != DECIDE);
    for (int i = 0; i < N_PHASE; i++) begin
      if (cur_phase_d == PH_W'(i)) begin
        light_green_d[i]  = (state_d == GREEN) || (state_d == DECIDE);
        light_yellow_d[i] = (state_d == YELLOW);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q        <= IDLE;
      cur_phase_q    <= '0;
      pend_phase_q   <= '0;
      pend_valid_q   <= 1'b0;
      act_ready_q    <= 1'b0;
      step_done_q    <= 1'b0;
      act_err_q      <= 1'b0;
      light_green_q  <= '0;
      light_yellow_q <= '0;
    end else begin
      state_q        <= state_d;
      cur_phase_q    <= cur_phase_d;
      pend_phase_q   <= pend_phase_d;
      pend_valid_q   <= pend_valid_d;
      act_ready_q    <= act_ready_d;
      step_done_q    <= step_done_d;
      act_err_q      <= act_err_d;
      light_green_q  <= light_green_d;
      light_yellow_q <= light_yellow_d;
    end
  end

`ifdef INTELLIGHT_SWITCH_CNT_EN
  logic [31:0] switch_cnt_q, switch_cnt_d;

  always_comb begin
    switch_cnt_d = switch_cnt_q;
    if ((state_q == ALLRED) && cnt_expire && pend_valid_q) begin
      switch_cnt_d = switch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      switch_cnt_q <= '0;
    end else begin
      switch_cnt_q <= switch_cnt_d;
    end
  end

  assign switch_cnt = switch_cnt_q;
`else
  assign switch_cnt = '0;
`endif

  assign act_if.act_ready = act_ready_q;
  assign light_green      = light_green_q;
  assign light_yellow     = light_yellow_q;
  assign cur_phase        = cur_phase_q;
  assign seq_state        = state_q;
  assign step_done        = step_done_q;
  assign act_err          = act_err_q;

endmodule

// File: tb/tb_intellight_phase_sequencer.sv
// Self-checking bench for intellight_phase_sequencer: vector table, hand-written corner sequences,
// and randomized traffic against an interval-plan reference model.
module tb_intellight_phase_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        enable;
  logic [15:0] green_cycles, yellow_cycles, allred_cycles;
  logic [3:0]  light_green, light_yellow;
  logic [2:0]  cur_phase, seq_state;
  logic        step_done, act_err;
  logic [31:0] switch_cnt;

  int checks   = 0;
  int failures = 0;

  intellight_phase_sequencer_if #(.PH_W(3)) act_if ();

  intellight_phase_sequencer #(
    .N_PHASE (4),
    .PH_W    (3),
    .CNT_W   (16)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .enable        (enable),
    .green_cycles  (green_cycles),
    .yellow_cycles (yellow_cycles),
    .allred_cycles (allred_cycles),
    .act_if        (act_if),
    .light_green   (light_green),
    .light_yellow  (light_yellow),
    .cur_phase     (cur_phase),
    .seq_state     (seq_state),
    .step_done     (step_done),
    .act_err       (act_err),
    .switch_cnt    (switch_cnt)
  );

  always #5 ACLK = ~ACLK;

  // Reference model: the current interval plus a queue of planned intervals still to come.
  localparam int K_IDLE = 0, K_GREEN = 1, K_DECIDE = 2, K_YEL = 3, K_RED = 4;
  typedef struct { int kind; int ph; bit sw; } seg_t;

  int          m_kind, m_left;
  logic [2:0]  m_phase;
  logic        m_ready, m_step, m_err;
  logic [31:0] m_sw;
  seg_t        m_plan[$];

  function automatic seg_t mk(input int kind, input int ph, input bit sw);
    seg_t s;
    s.kind = kind; s.ph = ph; s.sw = sw;
    return s;
  endfunction

  function automatic int dur(input logic [15:0] x);
    return (x == 16'd0) ? 1 : int'(x);
  endfunction

  function automatic logic [31:0] sw_exp(input logic [31:0] x);
`ifdef INTELLIGHT_SWITCH_CNT_EN
    return x;
`else
    return (x & 32'd0);
`endif
  endfunction

  task automatic m_start(input seg_t s);
    m_kind = s.kind;
    case (s.kind)
      K_GREEN: begin
        m_phase = 3'(s.ph);
        m_left  = dur(green_cycles);
        if (s.sw) m_sw = m_sw + 32'd1;
      end
      K_YEL:    m_left = dur(yellow_cycles);
      K_RED:    m_left = dur(allred_cycles);
      K_DECIDE: m_step = 1'b1;
      default:  m_left = 0;
    endcase
  endtask

  task automatic model_edge();
    bit acc;
    int ph;
    acc    = act_if.act_valid && m_ready;
    ph     = int'(act_if.act_phase);
    m_step = 1'b0;
    m_err  = 1'b0;
    if (!ARESETN) begin
      m_kind = K_IDLE; m_left = 0; m_phase = 3'd0; m_ready = 1'b0; m_sw = 32'd0;
      m_plan.delete();
      return;
    end
    case (m_kind)
      K_IDLE: begin
        if (acc) begin
          if (ph >= 4) m_err = 1'b1;
          else begin
            m_plan.delete();
            m_plan.push_back(mk(K_DECIDE, ph, 1'b0));
            m_start(mk(K_GREEN, ph, 1'b0));
          end
        end
      end
      K_DECIDE: begin
        if (acc && (ph >= 4 || ph == int'(m_phase))) begin
          m_err = (ph >= 4);
          m_plan.delete();
          m_plan.push_back(mk(K_DECIDE, 0, 1'b0));
          m_start(mk(K_GREEN, int'(m_phase), 1'b0));
        end else if (acc) begin
          m_plan.delete();
          m_plan.push_back(mk(K_RED, 0, 1'b0));
          m_plan.push_back(mk(K_GREEN, ph, 1'b1));
          m_plan.push_back(mk(K_DECIDE, 0, 1'b0));
          m_start(mk(K_YEL, 0, 1'b0));
        end else if (!enable) begin
          m_plan.delete();
          m_plan.push_back(mk(K_RED, 0, 1'b0));
          m_plan.push_back(mk(K_IDLE, 0, 1'b0));
          m_start(mk(K_YEL, 0, 1'b0));
        end
      end
      default: begin
        m_left = m_left - 1;
        if (m_left == 0) m_start(m_plan.pop_front());
      end
    endcase
    m_ready = (m_kind == K_DECIDE) || (m_kind == K_IDLE && enable);
  endtask

  task automatic tick();
    @(posedge ACLK);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {15'd0, light_green, light_yellow, seq_state, act_if.act_ready, step_done, act_err,
            cur_phase, switch_cnt};
  endfunction

  typedef struct {
    logic rst_n, en, v; logic [2:0] ph; int n;
    logic [3:0] g, y; logic [2:0] st; logic rdy, step, err; logic [2:0] cph; logic [31:0] sw;
  } vec_t;

  function automatic vec_t mkv(input logic rst_n, en, v, input logic [2:0] ph, input int n,
                               input logic [3:0] g, y, input logic [2:0] st,
                               input logic rdy, step, err, input logic [2:0] cph,
                               input logic [31:0] sw);
    vec_t r;
    r.rst_n = rst_n; r.en = en; r.v = v; r.ph = ph; r.n = n;
    r.g = g; r.y = y; r.st = st; r.rdy = rdy; r.step = step; r.err = err; r.cph = cph; r.sw = sw;
    return r;
  endfunction

  task automatic hcheck(input string name, input logic [2:0] st, input logic [3:0] g,
                        input logic [3:0] y);
    check(name, {53'd0, seq_state, light_green, light_yellow}, {53'd0, st, g, y});
  endtask

  vec_t tbl[$];
  logic [3:0]  eg, ey;
  logic [63:0] ev;
  logic        pre_ready, accepted;

  initial begin
    ARESETN = 1'b0; enable = 1'b1;
    act_if.act_valid = 1'b0; act_if.act_phase = 3'd0;
    green_cycles = 16'd5; yellow_cycles = 16'd2; allred_cycles = 16'd1;

    //                 rst en v  ph  n  green    yellow   st rdy stp err cph sw
    tbl.push_back(mkv(0, 1, 0, 0, 2, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 0, 0, 1, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 1, 2, 1, 4'b0100, 4'b0000, 1, 0, 0, 0, 2, 0));
    tbl.push_back(mkv(1, 1, 0, 2, 4, 4'b0100, 4'b0000, 1, 0, 0, 0, 2, 0));
    tbl.push_back(mkv(1, 1, 0, 2, 1, 4'b0100, 4'b0000, 2, 1, 1, 0, 2, 0));
    tbl.push_back(mkv(1, 1, 0, 2, 2, 4'b0100, 4'b0000, 2, 1, 0, 0, 2, 0));
    tbl.push_back(mkv(1, 1, 1, 0, 1, 4'b0000, 4'b0100, 3, 0, 0, 0, 2, 0));
    tbl.push_back(mkv(1, 1, 0, 0, 1, 4'b0000, 4'b0100, 3, 0, 0, 0, 2, 0));
    tbl.push_back(mkv(1, 1, 0, 0, 1, 4'b0000, 4'b0000, 4, 0, 0, 0, 2, 0));
    tbl.push_back(mkv(1, 1, 0, 0, 5, 4'b0001, 4'b0000, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(1, 1, 0, 0, 1, 4'b0001, 4'b0000, 2, 1, 1, 0, 0, 1));
    tbl.push_back(mkv(1, 1, 1, 0, 1, 4'b0001, 4'b0000, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(1, 1, 0, 0, 4, 4'b0001, 4'b0000, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(1, 1, 0, 0, 1, 4'b0001, 4'b0000, 2, 1, 1, 0, 0, 1));
    tbl.push_back(mkv(1, 1, 1, 7, 1, 4'b0001, 4'b0000, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mkv(1, 1, 0, 0, 4, 4'b0001, 4'b0000, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(1, 1, 0, 0, 1, 4'b0001, 4'b0000, 2, 1, 1, 0, 0, 1));
    tbl.push_back(mkv(1, 0, 0, 0, 2, 4'b0000, 4'b0001, 3, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(1, 0, 0, 0, 1, 4'b0000, 4'b0000, 4, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(1, 0, 0, 0, 3, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(1, 1, 0, 0, 1, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mkv(1, 1, 1, 7, 1, 4'b0000, 4'b0000, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mkv(1, 1, 0, 0, 1, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      ARESETN = tbl[i].rst_n; enable = tbl[i].en;
      act_if.act_valid = tbl[i].v; act_if.act_phase = tbl[i].ph;
      for (int k = 0; k < tbl[i].n; k++) begin
        tick();
        check($sformatf("vec%0d_cyc%0d", i, k), dut_vec(),
              {15'd0, tbl[i].g, tbl[i].y, tbl[i].st, tbl[i].rdy, tbl[i].step, tbl[i].err,
               tbl[i].cph, sw_exp(tbl[i].sw)});
      end
    end

    // Zero durations, then a green_cycles write in the middle of a green interval.
    ARESETN = 1'b0; act_if.act_valid = 1'b0; tick(); tick();
    ARESETN = 1'b1; tick();
    green_cycles = 16'd0; yellow_cycles = 16'd0; allred_cycles = 16'd0;
    act_if.act_valid = 1'b1; act_if.act_phase = 3'd1; tick();
    hcheck("zero_green", 3'd1, 4'b0010, 4'b0000);
    act_if.act_valid = 1'b0; tick();
    hcheck("zero_decide", 3'd2, 4'b0010, 4'b0000);
    act_if.act_valid = 1'b1; act_if.act_phase = 3'd3; tick();
    hcheck("zero_yellow", 3'd3, 4'b0000, 4'b0010);
    act_if.act_valid = 1'b0; tick();
    hcheck("zero_allred", 3'd4, 4'b0000, 4'b0000);
    tick();
    hcheck("zero_next_green", 3'd1, 4'b1000, 4'b0000);
    tick();
    hcheck("zero_next_decide", 3'd2, 4'b1000, 4'b0000);
    green_cycles = 16'd3;
    act_if.act_valid = 1'b1; act_if.act_phase = 3'd3; tick();
    act_if.act_valid = 1'b0; green_cycles = 16'd9;
    tick(); tick();
    hcheck("late_write_green3", 3'd1, 4'b1000, 4'b0000);
    tick();
    hcheck("late_write_decide", 3'd2, 4'b1000, 4'b0000);

    // Reset while yellow is lit.
    yellow_cycles = 16'd4;
    act_if.act_valid = 1'b1; act_if.act_phase = 3'd0; tick();
    hcheck("pre_reset_yellow", 3'd3, 4'b0000, 4'b1000);
    act_if.act_valid = 1'b0; ARESETN = 1'b0; tick();
    hcheck("reset_mid_yellow", 3'd0, 4'b0000, 4'b0000);
    check("reset_ready_phase", {62'd0, act_if.act_ready, step_done}, 64'd0);
    ARESETN = 1'b1;

    // Randomized traffic against the reference model.
    ARESETN = 1'b0; tick(); ARESETN = 1'b1;
    green_cycles = 16'd3; yellow_cycles = 16'd2; allred_cycles = 16'd1;
    accepted = 1'b0;
    for (int c = 0; c < 4000 && failures < 10; c++) begin
      if (!act_if.act_valid || accepted) begin
        act_if.act_valid = ($urandom_range(0, 2) != 0);
        act_if.act_phase = ($urandom_range(0, 9) != 0) ? 3'($urandom_range(0, 3))
                                                      : 3'($urandom_range(4, 7));
      end
      enable  = ($urandom_range(0, 15) != 0);
      ARESETN = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 19) == 0) green_cycles  = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) yellow_cycles = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) allred_cycles = 16'($urandom_range(0, 4));
      pre_ready = m_ready;
      tick();
      accepted = act_if.act_valid && pre_ready && ARESETN;
      eg = (m_kind == K_GREEN || m_kind == K_DECIDE) ? (4'b0001 << m_phase) : 4'b0000;
      ey = (m_kind == K_YEL) ? (4'b0001 << m_phase) : 4'b0000;
      ev = {15'd0, eg, ey, 3'(m_kind), m_ready, m_step, m_err, m_phase, sw_exp(m_sw)};
      check($sformatf("rand_cyc%0d", c), dut_vec(), ev);
      check($sformatf("rand_safety%0d", c), {63'd0, $onehot0({light_green, light_yellow})}, 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intellight_phase_sequencer.md
# intellight_phase_sequencer

- Sequences the intersection signal heads for the intellight traffic controller: GREEN → YELLOW → ALL-RED clearance → next GREEN.
- Accepts the next-phase decision from the learning agent over a valid/ready handshake.
- Interval durations come from the AXI4-Lite register file.
- Sits between the register file/agent and the lamp driver outputs, and pulses `step_done` at every decision point so the agent can sample state.

## Interface
- `N_PHASE`, 4: number of signal phases (approaches).
- `PH_W`, `$clog2(N_PHASE)`: phase index width.
- `CNT_W`, 16: interval counter width.
- `ACLK`, in, 1: clock.
- `ARESETN`, in, 1: reset. One clock; reset is synchronous and active-low.
- `enable`, in, 1: run control from the register file.
- `green_cycles`, in, CNT_W: green interval length in clocks.
- `yellow_cycles`, in, CNT_W: yellow interval length in clocks.
- `allred_cycles`, in, CNT_W: all-red clearance length in clocks.
- `act_valid`, in, 1: agent action valid.
- `act_phase`, in, PH_W: requested phase.
- `act_ready`, out, 1: sequencer accepts an action.
- `light_green`, out, N_PHASE: one-hot green lamps.
- `light_yellow`, out, N_PHASE: one-hot yellow lamps. Red is implied where neither is set.
- `cur_phase`, out, PH_W: phase currently or last served.
- `seq_state`, out, 3: FSM state encoding, for status readback.
- `step_done`, out, 1: one-cycle pulse on entering DECIDE.
- `act_err`, out, 1: one-cycle pulse when an out-of-range action is accepted.
- `switch_cnt`, out, 32: phase-change counter.

## Operation
- **States:** IDLE, GREEN, DECIDE, YELLOW, ALLRED.
- **IDLE (reset state):**
  - All lamps red; `act_ready = enable`.
  - On an accepted in-range action: `cur_phase <= act_phase`, load the counter with `green_cycles`, go to GREEN.
  - An out-of-range action (`act_phase >= N_PHASE`) is consumed, pulses `act_err`, and the FSM stays in IDLE.
- **GREEN:**
  - `light_green[cur_phase] = 1`; the counter decrements every clock.
  - On the last cycle, go to DECIDE.
  - `act_ready = 0`.
- **DECIDE:**
  - Green held, `act_ready = 1`; `step_done` pulses on the entry cycle.
  - Action equal to `cur_phase`, or out of range (which also pulses `act_err`): reload `green_cycles` and return to GREEN. This is a green extension with no yellow.
  - Any other in-range phase: latch it as the pending phase, then go to YELLOW loaded with `yellow_cycles`.
  - `enable` low with no handshake: go to YELLOW with no pending phase.
  - The sequencer waits indefinitely otherwise.
- **YELLOW:**
  - `light_yellow[cur_phase] = 1`.
  - On expiry, go to ALLRED loaded with `allred_cycles`.
- **ALLRED:**
  - All lamps red.
  - On expiry with a pending phase: `cur_phase <= pending`, increment `switch_cnt`, GREEN.
  - On expiry with no pending phase: IDLE.
- **Duration rules:**
  - Durations are sampled only at interval load; register changes mid-interval take effect at the next load.
  - A loaded value of 0 is treated as 1.
  - An interval of N lasts exactly N clocks.
- **`enable` deassertion:**
  - During GREEN, YELLOW or ALLRED, the current interval and sequence complete normally.
  - It is acted on only in DECIDE and IDLE.
  - A pending phase change is still completed.
- **Safety invariant:** at most one green or yellow lamp is lit at any time, and never green and yellow together.
- **`switch_cnt`:** wraps modulo 2^32 and is not incremented on green extension.

## Timing
- **Reset values:** state IDLE; `light_green` = 0; `light_yellow` = 0; `cur_phase` = 0; `act_ready` = 0; `step_done` = 0; `act_err` = 0; `switch_cnt` = 0; pending cleared.
- **Reset mid-sequence:** on the next edge, all lamps are red and the FSM is in IDLE.
- **Handshake:** a transfer occurs on the edge where `act_valid && act_ready`. `act_valid` may assert before `act_ready`; the agent holds `act_phase` until the transfer.
- **Latency:**
  - Acceptance in IDLE/DECIDE at edge t: the GREEN or YELLOW lamp is visible from t+1.
  - `step_done` asserts in the same cycle `act_ready` first rises in DECIDE.
- **Outputs:** all outputs are registered; there are no combinational paths from `act_valid` to lamps.

## Configuration
- **`INTELLIGHT_SWITCH_CNT_EN` defined:** `switch_cnt` is a live 32-bit counter with the behaviour above.
- **Not defined:** no counter flops are built and `switch_cnt` is tied to 0.

## Structure
- **`intellight_pkg`:**
  - `seq_state_t` enum (IDLE=0, GREEN=1, DECIDE=2, YELLOW=3, ALLRED=4).
  - Default durations.
  - `N_PHASE` default.
- **Sub-module `intellight_interval_cnt`:** CNT_W loadable down-counter with zero-to-one clamp and an `expire` flag on the last cycle; one instance.

## Test plan
- **Basic sequence:** reset, `enable=1`, green=5/yellow=2/allred=1, action phase 2 → `light_green=4'b0100` for 5 cycles, `step_done` pulse, `act_ready=1`.
- **Phase change:** in DECIDE, action phase 0 → `light_yellow=4'b0100` 2 cycles, all-red 1 cycle, then `light_green=4'b0001`; `switch_cnt=1`.
- **Green extension:** in DECIDE, action equal to `cur_phase` → green held continuously for another 5 cycles, no yellow, `switch_cnt` unchanged.
- **Zero durations / late register write:** zero durations → each interval lasts 1 cycle; `green_cycles` written mid-GREEN → current interval unaffected.
- **Out-of-range action:** action phase 7 with N_PHASE=4 → `act_err` pulse, green extended (DECIDE) or FSM stays IDLE.
- **Enable drop and reset:** `enable=0` in DECIDE → yellow, all-red, IDLE, `act_ready=0`; `ARESETN=0` during YELLOW → all lamps 0 on the next edge, `seq_state=0`.
